// File: rtl/vga_color_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_color_sink_if
// Description : Colour-word input and VGA pin/timing outputs of the
//               vga_color_sink display block, bundled as one interface.
//               The colour generator side uses the master modport and the
//               display sink uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_color_sink_if;
    logic [7:0] RGB_in;
    logic [2:0] VGA_R;
    logic [2:0] VGA_G;
    logic [1:0] VGA_B;
    logic       HSYNC;
    logic       VSYNC;
    logic       ACTIVE;
    logic [9:0] PIXEL_X;
    logic [9:0] PIXEL_Y;
    logic       FRAME_START;

    // Colour generator side: supplies the colour word, observes timing.
    modport master (
        output RGB_in,
        input  VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, ACTIVE,
        input  PIXEL_X, PIXEL_Y, FRAME_START
    );

    // Display sink side: consumes the colour word, drives pins and timing.
    modport slave (
        input  RGB_in,
        output VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, ACTIVE,
        output PIXEL_X, PIXEL_Y, FRAME_START
    );
endinterface
`default_nettype wire

// File: rtl/vga_color_sink.sv
`default_nettype none
// ============================================================================
// Module      : vga_color_sink
// Description : VGA timing generator and colour output stage. Divides CLK_IN
//               down to the pixel rate, walks the (h,v) raster, latches a
//               frame-stable copy of the RGB332 colour word at every wrap to
//               (0,0) and drives it onto the DAC pins inside the visible area.
//               All outputs are registered and computed from the next raster
//               position so timing, position and colour stay aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_color_sink #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic          CLK_IN,
    input  wire logic          RESET_N,
    vga_color_sink_if.slave    bus
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // A divider of 1 still needs a one-bit counter that simply sits at zero.
    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_h;
    logic [9:0]         r_v;
    logic [7:0]         r_color_q;

    logic [2:0]         r_vga_r;
    logic [2:0]         r_vga_g;
    logic [1:0]         r_vga_b;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_active;
    logic               r_frame_start;

    logic               w_pix_en;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_wrap;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;
    logic [7:0]         w_color_next;
    logic               w_active_next;
    logic               w_hsync_next;
    logic               w_vsync_next;

    assign w_pix_en = (r_div == c_DIV_LAST);

    // Next raster position and the output values that belong to it.
    always_comb begin
        w_h_last      = (r_h == c_H_LAST);
        w_v_last      = (r_v == c_V_LAST);
        w_h_next      = w_h_last ? 10'd0 : r_h + 10'd1;
        w_v_next      = r_v;
        if (w_h_last) begin
            w_v_next  = w_v_last ? 10'd0 : r_v + 10'd1;
        end
        w_wrap        = w_pix_en && w_h_last && w_v_last;
        // The colour for pixel (0,0) of the new frame is the one captured now.
        w_color_next  = w_wrap ? bus.RGB_in : r_color_q;
        w_active_next = (w_h_next < c_H_ACT) && (w_v_next < c_V_ACT);
        w_hsync_next  = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
        w_vsync_next  = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
    end

    // Pixel-rate divider: free-running modulo CLK_DIV counter.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster counters and frame-stable colour shadow, advanced per pixel.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_h       <= 10'd0;
            r_v       <= 10'd0;
            r_color_q <= 8'h00;
        end else if (w_pix_en) begin
            r_h       <= w_h_next;
            r_v       <= w_v_next;
            r_color_q <= w_color_next;
        end
    end

    // Registered pin/timing outputs, all taken from the new raster position.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vga_r  <= 3'd0;
            r_vga_g  <= 3'd0;
            r_vga_b  <= 2'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b0;
        end else if (w_pix_en) begin
            r_vga_r  <= w_active_next ? w_color_next[7:5] : 3'd0;
            r_vga_g  <= w_active_next ? w_color_next[4:2] : 3'd0;
            r_vga_b  <= w_active_next ? w_color_next[1:0] : 2'd0;
            r_hsync  <= w_hsync_next;
            r_vsync  <= w_vsync_next;
            r_active <= w_active_next;
        end
    end

    // Frame-start strobe: high for exactly the CLK_IN cycle after a wrap.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
        end
    end

    assign bus.VGA_R       = r_vga_r;
    assign bus.VGA_G       = r_vga_g;
    assign bus.VGA_B       = r_vga_b;
    assign bus.HSYNC       = r_hsync;
    assign bus.VSYNC       = r_vsync;
    assign bus.ACTIVE      = r_active;
    assign bus.PIXEL_X     = r_h;
    assign bus.PIXEL_Y     = r_v;
    assign bus.FRAME_START = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_color_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_color_sink
// Description : Scoreboard bench for vga_color_sink. Two instances (pixel
//               divider 2 and 1) run a reduced raster so several frames fit
//               in a short run. A reference model derives the expected pin
//               state from the elapsed clock count with plain arithmetic and
//               queues it; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_color_sink;

    localparam int c_HA = 8;
    localparam int c_HF = 2;
    localparam int c_HS = 3;
    localparam int c_HB = 2;
    localparam int c_VA = 5;
    localparam int c_VF = 1;
    localparam int c_VS = 2;
    localparam int c_VB = 2;
    localparam int c_HT = c_HA + c_HF + c_HS + c_HB;
    localparam int c_VT = c_VA + c_VF + c_VS + c_VB;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
    } exp_t;

    localparam exp_t c_RESET_EXP = '{r: 3'd0, g: 3'd0, b: 2'd0, hs: 1'b1, vs: 1'b1,
                                     act: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0};

    logic       clk;
    logic       rst_n;
    logic [7:0] rgb;
    int         checks;
    int         errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int c_DIV = (gi == 0) ? 2 : 1;

        vga_color_sink_if u_bus ();
        assign u_bus.RGB_in = rgb;

        vga_color_sink #(
            .CLK_DIV  (c_DIV),
            .H_ACTIVE (c_HA), .H_FP (c_HF), .H_SYNC (c_HS), .H_BP (c_HB),
            .V_ACTIVE (c_VA), .V_FP (c_VF), .V_SYNC (c_VS), .V_BP (c_VB)
        ) u_dut (
            .CLK_IN  (clk),
            .RESET_N (rst_n),
            .bus     (u_bus)
        );

        exp_t       q[$];
        int         t;
        logic [7:0] frame_col;
        int         fs_exp;
        int         fs_seen;
        int         shown;

        initial begin
            fs_exp  = 0;
            fs_seen = 0;
            shown   = 0;
        end

        // Reference model: position is simply (clocks since release / divider)
        // modulo the frame size; colour is whatever RGB_in held at the last wrap.
        always @(posedge clk) begin : b_model
            exp_t e;
            int   n;
            int   p;
            int   x;
            int   y;
            if (!rst_n) begin
                t         = 0;
                frame_col = 8'h00;
                e         = c_RESET_EXP;
            end else begin
                t = t + 1;
                n = t / c_DIV;
                if (n == 0) begin
                    e = c_RESET_EXP;
                end else begin
                    p = n % (c_HT * c_VT);
                    x = p % c_HT;
                    y = p / c_HT;
                    e.fs = ((t % c_DIV) == 0) && (p == 0);
                    if (e.fs) begin
                        frame_col = rgb;
                        fs_exp    = fs_exp + 1;
                    end
                    e.act = (x < c_HA) && (y < c_VA);
                    e.hs  = !((x >= c_HA + c_HF) && (x < c_HA + c_HF + c_HS));
                    e.vs  = !((y >= c_VA + c_VF) && (y < c_VA + c_VF + c_VS));
                    e.px  = 10'(x);
                    e.py  = 10'(y);
                    e.r   = e.act ? frame_col[7:5] : 3'd0;
                    e.g   = e.act ? frame_col[4:2] : 3'd0;
                    e.b   = e.act ? frame_col[1:0] : 2'd0;
                end
            end
            q.push_back(e);
        end

        // Monitor: compare every presented output cycle against the queue.
        always @(negedge clk) begin : b_monitor
            exp_t a;
            exp_t e;
            a = {u_bus.VGA_R, u_bus.VGA_G, u_bus.VGA_B, u_bus.HSYNC, u_bus.VSYNC,
                 u_bus.ACTIVE, u_bus.PIXEL_X, u_bus.PIXEL_Y, u_bus.FRAME_START};
            fs_seen = fs_seen + int'(a.fs);
            checks  = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL cfg%0d scoreboard_empty got none required one entry", gi);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors = errors + 1;
                    if (shown < 20) begin
                        shown = shown + 1;
                        $display("FAIL cfg%0d pixel_out t=%0d got R%0d G%0d B%0d hs%0b vs%0b act%0b x%0d y%0d fs%0b required R%0d G%0d B%0d hs%0b vs%0b act%0b x%0d y%0d fs%0b",
                                 gi, t, a.r, a.g, a.b, a.hs, a.vs, a.act, a.px, a.py, a.fs,
                                 e.r, e.g, e.b, e.hs, e.vs, e.act, e.px, e.py, e.fs);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic run_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            // Mostly hold the colour for a while, sometimes change it mid-frame.
            if ($urandom_range(0, 7) == 0) rgb = 8'($urandom);
        end
    endtask

    initial begin : b_main
        bit found;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rgb    = 8'hE3;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        run_random(1300);

        // Wait for cfg0 to be inside the vertical sync pulse.
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (g_cfg[0].u_bus.VSYNC == 1'b0) found = 1'b1;
        end
        chk("vsync_seen_before_timeout", int'(found), 1);

        // Asynchronous reset mid-pulse: outputs must drop without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vsync",   int'(g_cfg[0].u_bus.VSYNC),       1);
        chk("async_rst_hsync",   int'(g_cfg[0].u_bus.HSYNC),       1);
        chk("async_rst_pixel_x", int'(g_cfg[0].u_bus.PIXEL_X),     0);
        chk("async_rst_pixel_y", int'(g_cfg[0].u_bus.PIXEL_Y),     0);
        chk("async_rst_pins",    int'({g_cfg[0].u_bus.VGA_R, g_cfg[0].u_bus.VGA_G,
                                       g_cfg[0].u_bus.VGA_B}),     0);
        chk("async_rst_active",  int'(g_cfg[0].u_bus.ACTIVE),      0);
        chk("async_rst_fs",      int'(g_cfg[0].u_bus.FRAME_START), 0);
        chk("async_rst_cfg1_y",  int'(g_cfg[1].u_bus.PIXEL_Y),     0);

        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_random(900);
        @(negedge clk);

        chk("cfg0_frame_start_count", g_cfg[0].fs_seen, g_cfg[0].fs_exp);
        chk("cfg1_frame_start_count", g_cfg[1].fs_seen, g_cfg[1].fs_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
